// File: rtl/imm_compressor.sv
// Compresses a 32-bit operand into a 5/14/24-bit immediate field and flags whether the field round-trips exactly.
// Two registered stages, 2-cycle latency; valid/ready with full throughput, stalls hold S2 stable when out_ready is low.
module imm_compressor #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_signop,
   input  logic              in_auto,
   input  logic [1:0]        in_exsrc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [23:0]       out_field,
   output logic [1:0]        out_exsrc,
   output logic              out_fits,
   input  logic              clr_count,
   output logic [CNT_W-1:0]  ovf_count
);

   logic              rdy_en_q;
   logic              s1_vld_q, s1_vld_d;
   logic [23:0]       s1_data_q, s1_data_d;
   logic              s1_auto_q, s1_auto_d;
   logic [1:0]        s1_exsrc_q, s1_exsrc_d;
   logic              s1_fit5_q, s1_fit5_d;
   logic              s1_fit14_q, s1_fit14_d;
   logic              s1_fit24_q, s1_fit24_d;

   logic              out_vld_q, out_vld_d;
   logic [23:0]       out_field_q, out_field_d;
   logic [1:0]        out_exsrc_q, out_exsrc_d;
   logic              out_fits_q, out_fits_d;
   logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;

   logic              advance;
   logic              fit5_c, fit14_c, fit24_c;
   logic [1:0]        sel_code;
   logic              sel_fits;

   assign advance   = !out_vld_q || out_ready;
   assign in_ready  = rdy_en_q && (!s1_vld_q || advance);
   assign out_valid = out_vld_q;
   assign out_field = out_field_q;
   assign out_exsrc = out_exsrc_q;
   assign out_fits  = out_fits_q;
   assign ovf_count = ovf_count_q;

   // Signed fit: every bit from the field's sign bit upward matches; unsigned fit: all bits above the field are zero.
   always_comb begin
      fit5_c  = 1'b0;
      fit14_c = 1'b0;
      fit24_c = 1'b0;
      if (in_signop) begin
         fit5_c  = (&in_data[DATA_W-1:4])  | ~(|in_data[DATA_W-1:4]);
         fit14_c = (&in_data[DATA_W-1:13]) | ~(|in_data[DATA_W-1:13]);
         fit24_c = (&in_data[DATA_W-1:23]) | ~(|in_data[DATA_W-1:23]);
      end else begin
         fit5_c  = ~(|in_data[DATA_W-1:5]);
         fit14_c = ~(|in_data[DATA_W-1:14]);
         fit24_c = ~(|in_data[DATA_W-1:24]);
      end
   end

   always_comb begin
      s1_vld_d   = s1_vld_q;
      s1_data_d  = s1_data_q;
      s1_auto_d  = s1_auto_q;
      s1_exsrc_d = s1_exsrc_q;
      s1_fit5_d  = s1_fit5_q;
      s1_fit14_d = s1_fit14_q;
      s1_fit24_d = s1_fit24_q;
      if (in_ready) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_data_d  = in_data[23:0];
            s1_auto_d  = in_auto;
            s1_exsrc_d = in_exsrc;
            s1_fit5_d  = fit5_c;
            s1_fit14_d = fit14_c;
            s1_fit24_d = fit24_c;
         end
      end
   end

   always_comb begin
      sel_code = 2'd2;
      sel_fits = s1_fit24_q;
      if (s1_auto_q) begin
         if (s1_fit5_q) begin
            sel_code = 2'd0;
            sel_fits = 1'b1;
         end else if (s1_fit14_q) begin
            sel_code = 2'd1;
            sel_fits = 1'b1;
         end
      end else begin
         case (s1_exsrc_q)
            2'd0:    begin sel_code = 2'd0; sel_fits = s1_fit5_q;  end
            2'd1:    begin sel_code = 2'd1; sel_fits = s1_fit14_q; end
            default: begin sel_code = 2'd2; sel_fits = s1_fit24_q; end
         endcase
      end
   end

   always_comb begin
      out_vld_d   = out_vld_q;
      out_field_d = out_field_q;
      out_exsrc_d = out_exsrc_q;
      out_fits_d  = out_fits_q;
      if (advance) begin
         out_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            out_exsrc_d = sel_code;
            out_fits_d  = sel_fits;
            case (sel_code)
               2'd0:    out_field_d = {19'd0, s1_data_q[4:0]};
               2'd1:    out_field_d = {10'd0, s1_data_q[13:0]};
               default: out_field_d = s1_data_q;
            endcase
         end
      end
   end

   // Clear has priority over a same-cycle overflow increment.
   always_comb begin
      ovf_count_d = ovf_count_q;
      if (clr_count) begin
         ovf_count_d = '0;
      end else if (out_vld_q && out_ready && !out_fits_q && (ovf_count_q != {CNT_W{1'b1}})) begin
         ovf_count_d = ovf_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q    <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_data_q   <= '0;
         s1_auto_q   <= 1'b0;
         s1_exsrc_q  <= 2'd0;
         s1_fit5_q   <= 1'b0;
         s1_fit14_q  <= 1'b0;
         s1_fit24_q  <= 1'b0;
         out_vld_q   <= 1'b0;
         out_field_q <= '0;
         out_exsrc_q <= 2'd0;
         out_fits_q  <= 1'b0;
         ovf_count_q <= '0;
      end else begin
         rdy_en_q    <= 1'b1;
         s1_vld_q    <= s1_vld_d;
         s1_data_q   <= s1_data_d;
         s1_auto_q   <= s1_auto_d;
         s1_exsrc_q  <= s1_exsrc_d;
         s1_fit5_q   <= s1_fit5_d;
         s1_fit14_q  <= s1_fit14_d;
         s1_fit24_q  <= s1_fit24_d;
         out_vld_q   <= out_vld_d;
         out_field_q <= out_field_d;
         out_exsrc_q <= out_exsrc_d;
         out_fits_q  <= out_fits_d;
         ovf_count_q <= ovf_count_d;
      end
   end

endmodule

// File: tb/tb_imm_compressor.sv
// Directed-vector bench for imm_compressor: field selection, backpressure, reset flush and overflow counting.
module tb_imm_compressor;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_signop;
   logic        in_auto;
   logic [1:0]  in_exsrc;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_field;
   logic [1:0]  out_exsrc;
   logic        out_fits;
   logic        clr_count;
   logic [7:0]  ovf_count;

   int n_tests = 0;
   int n_fail  = 0;

   imm_compressor #(.DATA_W(32), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_signop (in_signop),
      .in_auto   (in_auto),
      .in_exsrc  (in_exsrc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_field (out_field),
      .out_exsrc (out_exsrc),
      .out_fits  (out_fits),
      .clr_count (clr_count),
      .ovf_count (ovf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents one beat at a falling edge and checks the result two rising edges later, before it transfers.
   task automatic run_beat(input string tag, input logic [31:0] d, input logic s, input logic a,
                           input logic [1:0] x, input logic [1:0] e_code, input logic [23:0] e_field,
                           input logic e_fits);
      in_data   = d;
      in_signop = s;
      in_auto   = a;
      in_exsrc  = x;
      in_valid  = 1'b1;
      check_val({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_val({tag, "_valid"}, out_valid, 1);
      check_val({tag, "_exsrc"}, out_exsrc, e_code);
      check_val({tag, "_field"}, out_field, e_field);
      check_val({tag, "_fits"}, out_fits, e_fits);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_signop = 1'b0;
      in_auto   = 1'b1;
      in_exsrc  = 2'd0;
      out_ready = 1'b1;
      clr_count = 1'b0;

      @(negedge clk);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_in_ready", in_ready, 0);
      check_val("rst_ovf", ovf_count, 0);
      check_val("rst_field", out_field, 0);
      check_val("rst_fits", out_fits, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check_val("rel_in_ready_low", in_ready, 0);
      @(negedge clk);
      check_val("rel_in_ready_high", in_ready, 1);

      // Field selection vectors
      run_beat("neg16_auto", 32'hFFFF_FFF0, 1'b1, 1'b1, 2'd0, 2'd0, 24'h000010, 1'b1);
      run_beat("p16_unsigned", 32'h0000_0010, 1'b0, 1'b1, 2'd0, 2'd0, 24'h000010, 1'b1);
      run_beat("p16_signed", 32'h0000_0010, 1'b1, 1'b1, 2'd0, 2'd1, 24'h000010, 1'b1);
      run_beat("nofit_signed", 32'h0100_0000, 1'b1, 1'b1, 2'd0, 2'd2, 24'h000000, 1'b0);
      check_val("ovf_before_xfer", ovf_count, 0);
      @(negedge clk);
      check_val("ovf_after_xfer", ovf_count, 1);
      run_beat("forced5_trunc", 32'h0000_0020, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000, 1'b0);
      run_beat("forced3_as24", 32'h00AB_CDEF, 1'b0, 1'b0, 2'd3, 2'd2, 24'hABCDEF, 1'b1);
      run_beat("forced14_neg", 32'hFFFF_E000, 1'b1, 1'b0, 2'd1, 2'd1, 24'h002000, 1'b1);
      run_beat("auto24_unsigned", 32'h0080_0000, 1'b0, 1'b1, 2'd0, 2'd2, 24'h800000, 1'b1);
      run_beat("auto24_signed_nofit", 32'h0080_0000, 1'b1, 1'b1, 2'd0, 2'd2, 24'h800000, 1'b0);
      @(negedge clk);
      check_val("ovf_three", ovf_count, 3);

      // Backpressure: three back-to-back beats while the consumer stalls
      out_ready = 1'b0;
      in_signop = 1'b0;
      in_auto   = 1'b1;
      in_data   = 32'd1;
      in_valid  = 1'b1;
      check_val("bp_rdy_a", in_ready, 1);
      @(negedge clk);
      in_data = 32'd2;
      check_val("bp_rdy_b", in_ready, 1);
      @(negedge clk);
      in_data = 32'd3;
      check_val("bp_rdy_c_blocked", in_ready, 0);
      check_val("bp_hold_valid", out_valid, 1);
      check_val("bp_hold_field1", out_field, 1);
      @(negedge clk);
      check_val("bp_still_field1", out_field, 1);
      check_val("bp_still_blocked", in_ready, 0);
      out_ready = 1'b1;
      #1;
      check_val("bp_rdy_comb", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check_val("bp_out_beat2", out_field, 2);
      @(negedge clk);
      check_val("bp_out_beat3", out_field, 3);
      check_val("bp_out_beat3_vld", out_valid, 1);
      @(negedge clk);
      check_val("bp_drained", out_valid, 0);

      // Reset with two beats in flight
      out_ready = 1'b0;
      in_data   = 32'h0100_0000;
      in_signop = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check_val("flush_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check_val("flush_out_valid", out_valid, 0);
      check_val("flush_ovf", ovf_count, 0);
      check_val("flush_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("flush_no_stale", out_valid, 0);
      end

      // 256 non-fitting beats streamed at full rate saturate the counter
      in_data   = 32'h0100_0000;
      in_signop = 1'b1;
      in_auto   = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 256; i++) begin
         if (i == 100) check_val("stream_in_ready", in_ready, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check_val("ovf_saturated", ovf_count, 255);

      // Clear coincident with a further non-fit transfer
      run_beat("clr_beat", 32'h0100_0000, 1'b1, 1'b1, 2'd0, 2'd2, 24'h000000, 1'b0);
      clr_count = 1'b1;
      @(negedge clk);
      clr_count = 1'b0;
      check_val("ovf_clear_wins", ovf_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_compressor.md
IMM_COMPRESSOR -- requirements
Module: imm_compressor

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the full operand width; the function is defined for 32 only.
REQ-002 The block SHALL have parameter CNT_W, default 8, the overflow counter width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts beat; transfer when in_valid && in_ready.
REQ-007 in_data  input  32  full-width value to compress into an immediate field.
REQ-008 in_signop  input  1  1 = signed field, 0 = unsigned field.
REQ-009 in_auto  input  1  1 = pick smallest fitting field; 0 = use in_exsrc.
REQ-010 in_exsrc  input  2  forced field size: 0 = 5 bits, 1 = 14 bits, 2 or 3 = 24 bits.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-013 out_field  output  24  in_data[j-1:0] for selected width j, zero above bit j-1.
REQ-014 out_exsrc  output  2  selected size code: 0, 1 or 2 (never 3).
REQ-015 out_fits  output  1  1 = selected field reproduces in_data exactly under sign/zero extension.
REQ-016 clr_count  input  1  synchronous clear of ovf_count.
REQ-017 ovf_count  output  CNT_W  number of delivered beats with out_fits = 0, saturating.

Function
REQ-018 Fit rule, width j in {5,14,24}: signed SHALL mean in_data[31:j-1] all equal; unsigned SHALL mean in_data[31:j] all zero.
REQ-019 Auto mode SHALL test 5, then 14, then 24 and select the first fit; with no fit it SHALL select code 2, out_fits = 0, out_field = in_data[23:0].
REQ-020 Forced mode SHALL select the in_exsrc width (code 3 reported as 2); out_fits SHALL be the fit flag for that width; out_field SHALL be the truncation regardless of fit.
REQ-021 Round-trip: when out_fits = 1, extending out_field[j-1:0] from bit j-1 (signed) or with zeros (unsigned) SHALL equal in_data.
REQ-022 The datapath SHALL be two registered stages: S1 captures inputs and computes the three fit flags; S2 holds selected code, field and fit flag.
REQ-023 Latency SHALL be 2 cycles: a beat accepted at edge N SHALL be on the outputs after edge N+2 when out_ready is held high.
REQ-024 S2 SHALL load when S2 is empty or out_ready = 1; S1 SHALL advance under the same condition.
REQ-025 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; it SHALL depend combinationally on out_ready only, not on in_valid.
REQ-026 Full throughput SHALL be one beat per cycle with out_ready = 1; no beat SHALL be dropped, duplicated or reordered.
REQ-027 While out_valid = 1 and out_ready = 0, out_field, out_exsrc and out_fits SHALL hold stable.
REQ-028 ovf_count SHALL increment on each output transfer with out_fits = 0 and saturate at 2^CNT_W-1.
REQ-029 clr_count SHALL set ovf_count to 0 at the next edge; clear SHALL win over a simultaneous increment.

Reset
REQ-030 rst_n low SHALL immediately clear both stage valid flags, out_valid = 0, out_field = 0, out_exsrc = 0, out_fits = 0, ovf_count = 0.
REQ-031 During reset in_ready SHALL be 0; it SHALL be 1 from the first edge after rst_n deasserts.
REQ-032 Reset mid-operation SHALL discard in-flight beats; no stale beat SHALL appear after release.

Verification
REQ-033 in_data = 0xFFFFFFF0, signop = 1, auto, out_ready = 1 -> two edges later out_exsrc = 0, out_field = 0x000010, out_fits = 1.
REQ-034 in_data = 0x00000010, auto -> signop = 0 gives exsrc 0, field 0x000010; signop = 1 gives exsrc 1, field 0x000010, fits 1.
REQ-035 in_data = 0x01000000, signop = 1, auto -> exsrc 2, field 0x000000, fits 0, ovf_count 0 -> 1 on transfer.
REQ-036 Forced in_exsrc = 0, in_data = 0x00000020, signop = 0 -> field 0x000000, fits 0, exsrc 0.
REQ-037 Send 3 back-to-back beats with out_ready = 0 -> in_ready drops after 2 accepted, outputs hold beat 1; raise out_ready -> beats 1, 2, 3 appear in order on consecutive cycles.
REQ-038 Assert rst_n = 0 with 2 beats in flight -> out_valid = 0 at once, ovf_count = 0, no output after release; then drive 256 non-fitting beats -> ovf_count = 255; clr_count coincident with a further non-fit transfer -> ovf_count = 0.
